// File: rtl/sha2_schedule_ctrl.sv
// ---------------------------------------------------------------------------
// sha2_schedule_ctrl
//
// Purpose:
//   Sequencer for a SHA-2 message-schedule shift register. It accepts one
//   16-word message block over a valid/ready handshake, loads it into the
//   external schedule register (ms_load/ms_din), then streams the R round
//   words W_0..W_{R-1} (read from ms_dout) to the compression core over a
//   second valid/ready handshake, advancing the schedule with ms_start on
//   every accepted word. R is 64 for MODE 224/256 and 80 for MODE 384/512.
//
// Parameters:
//   WIDTH  word width of the schedule datapath (default 32)
//   MODE   224, 256, 384 or 512; selects the round count
//
// Ports:
//   clk                      single clock, rising edge
//   rst                      synchronous reset, active low
//   blk_start                request to process one block (honoured in IDLE)
//   din / din_valid / din_ready   message-word input handshake
//   ms_load / ms_start / ms_din   controls for the schedule shift register
//   ms_dout                  schedule head word W_t
//   w_out / w_valid / w_ready / w_idx   round-word stream to the core
//   busy                     high while loading or streaming rounds
//   done                     one-cycle pulse after the last round word
//   abort                    (only with SHA2_SCHED_CTRL_ABORT_EN defined)
//                            discards the block in progress
//
// Build option:
//   SHA2_SCHED_CTRL_ABORT_EN  adds the abort input.
// ---------------------------------------------------------------------------
module sha2_schedule_ctrl #(
  parameter int WIDTH = 32,
  parameter int MODE  = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             blk_start,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ms_load,
  output logic             ms_start,
  output logic [WIDTH-1:0] ms_din,
  input  logic [WIDTH-1:0] ms_dout,
  output logic [WIDTH-1:0] w_out,
  output logic             w_valid,
  input  logic             w_ready,
  output logic [6:0]       w_idx,
  output logic             busy,
  output logic             done
`ifdef SHA2_SCHED_CTRL_ABORT_EN
  ,
  input  logic             abort
`endif
);

  // Index of the final round word for the selected digest size.
  localparam logic [6:0] LAST_ROUND = (MODE == 384 || MODE == 512) ? 7'd79 : 7'd63;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] word_cnt_reg, word_cnt_next;
  logic [6:0] round_cnt_reg, round_cnt_next;
  logic       abort_req;

`ifdef SHA2_SCHED_CTRL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      word_cnt_reg  <= 4'd0;
      round_cnt_reg <= 7'd0;
    end else begin
      state_reg     <= state_next;
      word_cnt_reg  <= word_cnt_next;
      round_cnt_reg <= round_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    word_cnt_next  = word_cnt_reg;
    round_cnt_next = round_cnt_reg;
    din_ready      = 1'b0;
    ms_load        = 1'b0;
    ms_start       = 1'b0;
    ms_din         = '0;
    w_out          = '0;
    w_valid        = 1'b0;
    w_idx          = 7'd0;
    busy           = 1'b0;
    done           = 1'b0;

    case (state_reg)
      IDLE: begin
        if (blk_start) begin
          state_next     = LOAD;
          word_cnt_next  = 4'd0;
          round_cnt_next = 7'd0;
        end
      end

      LOAD: begin
        busy      = 1'b1;
        din_ready = 1'b1;
        ms_din    = din;
        // An aborted cycle must not shift a word into the schedule.
        ms_load   = din_valid & ~abort_req;
        if (abort_req) begin
          state_next     = IDLE;
          word_cnt_next  = 4'd0;
          round_cnt_next = 7'd0;
        end else if (din_valid) begin
          // The 4-bit counter wraps to 0 on the 16th word, leaving it
          // clean for the next block.
          word_cnt_next = word_cnt_reg + 4'd1;
          if (word_cnt_reg == 4'd15) begin
            state_next = ROUND;
          end
        end
      end

      ROUND: begin
        busy     = 1'b1;
        w_valid  = 1'b1;
        w_out    = ms_dout;
        w_idx    = round_cnt_reg;
        ms_start = w_ready & ~abort_req;
        if (abort_req) begin
          state_next     = IDLE;
          word_cnt_next  = 4'd0;
          round_cnt_next = 7'd0;
        end else if (w_ready) begin
          // The counter stops at the last round instead of wrapping.
          if (round_cnt_reg == LAST_ROUND) begin
            state_next = DONE;
          end else begin
            round_cnt_next = round_cnt_reg + 7'd1;
          end
        end
      end

      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Reset is synchronous, so the state only clears at the edge; gate the
    // outputs here so they read zero for the whole time reset is held.
    if (!rst) begin
      din_ready = 1'b0;
      ms_load   = 1'b0;
      ms_start  = 1'b0;
      ms_din    = '0;
      w_out     = '0;
      w_valid   = 1'b0;
      w_idx     = 7'd0;
      busy      = 1'b0;
      done      = 1'b0;
    end
  end

endmodule
